// File: rtl/arb_pkg.sv
// Shared types and default widths for the L2 request arbiter.
package arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_D,
    REQ_I,
    REQ_P
  } req_e;

  typedef enum logic [2:0] {
    StIdle,
    StServeD,
    StServeI,
    StServeP,
    StDone
  } state_e;

endpackage

// File: rtl/l2_request_arbiter_if.sv
// Bundle of the L1/prefetcher request ports, the L2 port and the grant counters.
interface l2_request_arbiter_if
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned CNT_W  = 32
) ();

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              p_read;
  logic [ADDR_W-1:0] p_addr;
  logic [LINE_W-1:0] p_rdata;
  logic              p_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  cnt_i;
  logic [CNT_W-1:0]  cnt_p;

  modport slave (
    input  d_read, d_write, d_addr, d_wdata, i_read, i_addr, p_read, p_addr,
    input  mem_rdata, mem_resp,
    output d_rdata, d_resp, i_rdata, i_resp, p_rdata, p_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    output cnt_d, cnt_i, cnt_p
  );

  modport master (
    output d_read, d_write, d_addr, d_wdata, i_read, i_addr, p_read, p_addr,
    output mem_rdata, mem_resp,
    input  d_rdata, d_resp, i_rdata, i_resp, p_rdata, p_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    input  cnt_d, cnt_i, cnt_p
  );

endinterface

// File: rtl/arb_priority_sel.sv
// Combinational grant select: data over instruction over prefetch,
// with instruction forced ahead once data has starved it long enough.
module arb_priority_sel
  import arb_pkg::*;
(
  input  logic i_req_d,
  input  logic i_req_i,
  input  logic i_req_p,
  input  logic i_starved,
  output req_e o_grant
);

  always_comb begin
    o_grant = REQ_NONE;
    if (i_req_i && i_starved) begin
      o_grant = REQ_I;
    end else if (i_req_d) begin
      o_grant = REQ_D;
    end else if (i_req_i) begin
      o_grant = REQ_I;
    end else if (i_req_p) begin
      o_grant = REQ_P;
    end
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// Three-way arbiter sharing the L2 port between D-cache, I-cache and prefetcher;
// requests are captured on grant and held stable until the L2 completes.
module l2_request_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned LINE_W       = LINE_W_DEF,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 32
) (
  input logic                 clk,
  input logic                 rst,
  l2_request_arbiter_if.slave bus
);

  localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  state_e              r_state;
  state_e              w_state_next;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic [StarveW-1:0]  r_starve;
  logic [CNT_W-1:0]    r_cnt_d;
  logic [CNT_W-1:0]    r_cnt_i;
  logic [CNT_W-1:0]    r_cnt_p;

  req_e                w_grant;
  logic                w_req_d;
  logic                w_starved;
  logic                w_grant_valid;
  logic                w_serving;

  assign w_req_d       = bus.d_read | bus.d_write;
  assign w_starved     = (r_starve == StarveMax);
  assign w_grant_valid = (r_state == StIdle) && (w_grant != REQ_NONE);
  assign w_serving     = (r_state == StServeD) || (r_state == StServeI) ||
                         (r_state == StServeP);

  arb_priority_sel u_sel (
    .i_req_d   (w_req_d),
    .i_req_i   (bus.i_read),
    .i_req_p   (bus.p_read),
    .i_starved (w_starved),
    .o_grant   (w_grant)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        unique case (w_grant)
          REQ_D:   w_state_next = StServeD;
          REQ_I:   w_state_next = StServeI;
          REQ_P:   w_state_next = StServeP;
          default: w_state_next = StIdle;
        endcase
      end
      StServeD, StServeI, StServeP: begin
        if (bus.mem_resp) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_starve    <= '0;
      r_cnt_d     <= '0;
      r_cnt_i     <= '0;
      r_cnt_p     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_valid) begin
        unique case (w_grant)
          REQ_D: begin
            // A writeback takes precedence when both read and write are raised.
            r_mem_write <= bus.d_write;
            r_mem_read  <= ~bus.d_write;
            r_addr      <= bus.d_addr;
            if (bus.d_write) r_wdata <= bus.d_wdata;
            r_cnt_d     <= r_cnt_d + CNT_W'(1);
            if (!bus.i_read)        r_starve <= '0;
            else if (!w_starved)    r_starve <= r_starve + StarveW'(1);
          end
          REQ_I: begin
            r_mem_read <= 1'b1;
            r_addr     <= bus.i_addr;
            r_cnt_i    <= r_cnt_i + CNT_W'(1);
            r_starve   <= '0;
          end
          REQ_P: begin
            r_mem_read <= 1'b1;
            r_addr     <= bus.p_addr;
            r_cnt_p    <= r_cnt_p + CNT_W'(1);
          end
          default: ;
        endcase
      end else if (w_serving && bus.mem_resp) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
      end
    end
  end

  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_address = r_addr;
  assign bus.mem_wdata   = r_wdata;

  assign bus.d_resp  = (r_state == StServeD) && bus.mem_resp;
  assign bus.i_resp  = (r_state == StServeI) && bus.mem_resp;
  assign bus.p_resp  = (r_state == StServeP) && bus.mem_resp;
  assign bus.d_rdata = bus.mem_rdata;
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.p_rdata = bus.mem_rdata;

  assign bus.cnt_d = r_cnt_d;
  assign bus.cnt_i = r_cnt_i;
  assign bus.cnt_p = r_cnt_p;

endmodule

// File: doc/l2_request_arbiter.md
Name: l2_request_arbiter

Overview:
Three-requester arbiter in front of the unified L2 port. It shares that port between the D-cache, the I-cache and a new next-line instruction prefetcher. The block adds a data-over-instruction priority scheme with an anti-starvation escape, registered request capture, and per-requester grant counters. It sits between the L1 caches/prefetcher and l2_cache, in place of the two-way L1 arbitration.

Parameters:
ADDR_W, 32, address width
LINE_W, 256, cacheline width
STARVE_LIMIT, 4, consecutive data grants tolerated while an instruction request waits
CNT_W, 32, width of each grant counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
d_read  in  1  D-cache line read request
d_write  in  1  D-cache line writeback request
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache writeback data
d_rdata  out  LINE_W  read data to D-cache
d_resp  out  1  D-cache completion pulse
i_read  in  1  I-cache line read request
i_addr  in  ADDR_W  I-cache line address
i_rdata  out  LINE_W  read data to I-cache
i_resp  out  1  I-cache completion pulse
p_read  in  1  prefetcher line read request
p_addr  in  ADDR_W  prefetch line address
p_rdata  out  LINE_W  read data to prefetcher
p_resp  out  1  prefetcher completion pulse
mem_read  out  1  L2 read
mem_write  out  1  L2 write
mem_address  out  ADDR_W  L2 address
mem_wdata  out  LINE_W  L2 write data
mem_rdata  in  LINE_W  L2 read data
mem_resp  in  1  L2 completion
cnt_d  out  CNT_W  D grants issued
cnt_i  out  CNT_W  I grants issued
cnt_p  out  CNT_W  prefetch grants issued

Behaviour:
- Reset (async, rst=1) returns the block to a known state:
  - state IDLE;
  - mem_read, mem_write, mem_address and mem_wdata all 0;
  - all *_resp outputs 0;
  - starve counter 0 and cnt_d/i/p all 0.
  - An L2 transaction in flight at reset is abandoned; l2_cache is reset concurrently.
- FSM states: IDLE, SERVE_D, SERVE_I, SERVE_P, DONE.
- IDLE arbitration (evaluated every IDLE cycle):
  - If i_read is asserted and starve == STARVE_LIMIT, grant I.
  - Otherwise grant D if d_read or d_write is asserted.
  - Otherwise grant I if i_read is asserted.
  - Otherwise grant P if p_read is asserted.
  - Otherwise stay in IDLE.
- On a grant, the following are registered:
  - the operation (write if d_write is set, else read; d_write wins when d_read and d_write are both high);
  - the address, and the wdata for a D write.
  - mem_read or mem_write is asserted from the next cycle (1-cycle request latency) and is held constant until mem_resp.
- mem_address and mem_wdata come from the captured registers. A requester that changes its inputs mid-transaction does not disturb the L2 request.
- SERVE_x with mem_resp=1:
  - x_resp=1 in the same cycle (combinational);
  - x_rdata = mem_rdata (all *_rdata outputs pass mem_rdata through at all times);
  - mem_read/mem_write deassert at the next edge;
  - next state is DONE.
- DONE lasts one cycle with no grant. This gives the requester a cycle to drop its request, so it is never re-served. DONE then returns to IDLE.
- Starve counter:
  - increments (saturating at STARVE_LIMIT) on each D grant made while i_read=1;
  - clears on any I grant;
  - clears on a D grant made while i_read=0.
- cnt_x increments by 1 on each grant to x and wraps modulo 2^CNT_W.
- Prefetch is granted only when D and I are both idle. A demand request arriving during SERVE_P waits for completion; it is not preempted.
- Back-to-back: the next grant can be made at the earliest in the IDLE cycle after DONE. Minimum spacing is L2 latency + 2 cycles.
- mem_resp outside the SERVE states is ignored; no *_resp is produced.

Decomposition:
- Shared package arb_pkg holds:
  - the requester enum (REQ_NONE, REQ_D, REQ_I, REQ_P);
  - the FSM state enum;
  - the LINE_W/ADDR_W default constants.
- One natural sub-module, arb_priority_sel: a combinational grant select taking the request vector and the starve flag and producing the requester enum. The FSM, capture registers and counters stay in the top.

Test Plan:
- Single D read: d_read=1, d_addr=0x0000_1000, mem_resp after 5 cycles with mem_rdata=A5..A5.
  - mem_read rises 1 cycle after the request; mem_address=0x1000.
  - d_resp is a 1-cycle pulse with d_rdata=A5..A5.
  - cnt_d=1; a new grant is not possible until 2 cycles after the response.
- Simultaneous D write and I read: d_write=1 (addr 0x2000, wdata 0x11..), i_read=1 (0x3000).
  - D is served first with mem_write=1 and mem_wdata=0x11...
  - I is served next at 0x3000.
  - Order: d_resp, then i_resp.
- Starvation: i_read held, d_read re-asserted immediately after every d_resp, STARVE_LIMIT=4.
  - Exactly 4 D grants occur, then the I grant.
  - The starve counter returns to 0.
- Prefetch yielding: p_read=1 with d_read and i_read low.
  - P is granted.
  - d_read raised during SERVE_P waits until p_resp and is granted in the IDLE after DONE.
  - p_read and i_read raised together: I is granted, not P.
- Mid-flight input change: d_addr changes 0x4000→0x5000 during SERVE_D → mem_address stays 0x4000.
- Reset mid-transaction: rst asserted during SERVE_I.
  - All mem_* and *_resp outputs clear immediately (async); counters are 0.
  - After release, a pending d_read is granted normally.
